// File: rtl/axi_pkg.sv
// Shared definitions for the AXI RAM responder: burst and response codes,
// plus the state encodings of the read and write engines.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational AXI burst address stepper: given the current beat address
// and the burst attributes, produces the address of the following beat.
//   addr      in   current beat byte address
//   size      in   log2 bytes per beat
//   len       in   beats minus one (sets the WRAP window)
//   burst     in   FIXED / INCR / WRAP (reserved code steps like INCR)
//   next_addr out  address of the next beat
module axi_burst_next_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 30
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr_addr = addr + step;
        // WRAP windows are (len+1)<<size bytes, a power of two for legal lens,
        // so wrapping is just keeping the upper bits of the current address.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave terminating the shared instruction/data memory port. Serves
// AR/R and AW/W/B bursts from an internal byte-writable word array and
// echoes transaction IDs. Read and write engines run independently.
//   clk, rst          clock, asynchronous active-high reset
//   s_axi_ar*         read address channel (lock/cache/prot ignored)
//   s_axi_r*          read data channel
//   s_axi_aw*         write address channel (lock/cache/prot ignored)
//   s_axi_w*          write data channel
//   s_axi_b*          write response channel
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_DATA | rvalid high, streaming beats until the rlast handshake
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an AW handshake
//   W_DATA | wready high, writing one beat per W handshake
//   W_RESP | bvalid high, waiting for the B handshake
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 12
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready
);

    localparam int WORDS = 1 << MEM_AW;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic unused_ok;
    assign unused_ok = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot,
                         s_axi_awlock, s_axi_awcache, s_axi_awprot};

    // ---------------- read engine ----------------
    rd_state_t             rd_state, rd_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_next_addr;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, r_hs;
    logic [MEM_AW-1:0]     ar_idx, rn_idx;
    logic                  ar_oob, rn_oob;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign ar_idx = s_axi_araddr[MEM_AW+1:2];
    assign ar_oob = |s_axi_araddr[ADDR_WIDTH-1:MEM_AW+2];
    assign rn_idx = r_next_addr[MEM_AW+1:2];
    assign rn_oob = |r_next_addr[ADDR_WIDTH-1:MEM_AW+2];

    axi_burst_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_next (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (s_axi_arvalid) rd_next = R_DATA;
            R_DATA:  if (s_axi_rready && s_axi_rlast) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        // arready is gated by rst so every output reads 0 while reset is held
        s_axi_arready = (rd_state == R_IDLE) && !rst;
        s_axi_rvalid  = (rd_state == R_DATA);
        s_axi_rlast   = (rd_state == R_DATA) && (r_beat == r_len);
        s_axi_rid     = r_id;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
    end

    // Array reads happen on the handshake edge itself so the next beat is
    // ready with no bubble; a write on the same edge is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_id    <= s_axi_arid;
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= s_axi_arsize;
            r_burst <= s_axi_arburst;
            r_beat  <= '0;
            rdata_q <= ar_oob ? '0 : mem[ar_idx];
            rresp_q <= ar_oob ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs && !s_axi_rlast) begin
            r_addr  <= r_next_addr;
            r_beat  <= r_beat + 8'd1;
            rdata_q <= rn_oob ? '0 : mem[rn_idx];
            rresp_q <= rn_oob ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ---------------- write engine ----------------
    wr_state_t             wr_state, wr_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_next_addr;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  aw_hs, w_hs;
    logic [MEM_AW-1:0]     w_idx;
    logic                  w_oob;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign w_idx = w_addr[MEM_AW+1:2];
    assign w_oob = |w_addr[ADDR_WIDTH-1:MEM_AW+2];

    axi_burst_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_next (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (s_axi_awvalid) wr_next = W_DATA;
            // termination follows the beat count, not wlast
            W_DATA:  if (s_axi_wvalid && (w_beat == w_len)) wr_next = W_RESP;
            W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (wr_state == W_IDLE) && !rst;
        s_axi_wready  = (wr_state == W_DATA);
        s_axi_bvalid  = (wr_state == W_RESP);
        s_axi_bid     = w_id;
        s_axi_bresp   = ((wr_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_addr  <= s_axi_awaddr;
            w_len   <= s_axi_awlen;
            w_size  <= s_axi_awsize;
            w_burst <= s_axi_awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr  <= w_next_addr;
            w_beat  <= w_beat + 8'd1;
            if (w_oob || (s_axi_wlast != (w_beat == w_len))) w_err <= 1'b1;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_oob) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
module tb_axi_ram_responder;
    import axi_pkg::*;

    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid, awid, rid, bid;
    logic [29:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0] rdata, wdata;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    axi_ram_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready)
    );

    logic [31:0] ref_mem [WORDS];
    logic [31:0] wq [$];
    logic [3:0]  sq [$];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, from the burst rules directly.
    function automatic logic [29:0] beat_addr(input logic [29:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int i);
        longint step, bytes, base, off;
        step = longint'(1) << size;
        case (burst)
            2'b00: return a;
            2'b10: begin
                bytes = (longint'(len) + 1) * step;
                base  = (longint'(a) / bytes) * bytes;
                off   = (longint'(a) - base + longint'(i) * step) % bytes;
                return 30'(base + off);
            end
            default: return 30'(longint'(a) + longint'(i) * step);
        endcase
    endfunction

    function automatic bit is_oob(input logic [29:0] a);
        return (a >> 14) != 0;
    endfunction

    task automatic fill_data(input int n, input bit full);
        wq.delete();
        sq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back($urandom);
            sq.push_back(full ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int last_at, input bit gaps);
        bit err = 0;
        bit got;
        int n;
        logic [29:0] a;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        n = 0;
        do begin @(negedge clk); got = awready; @(posedge clk); n++; end while (!got && n < 200);
        #1 awvalid = 0;
        if (!got) begin check_val("aw_timeout", 0, 1); return; end
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wvalid = 1; wdata = wq[i]; wstrb = sq[i];
            wlast  = (last_at < 0) ? (i == int'(len)) : (i == last_at);
            n = 0;
            do begin @(negedge clk); got = wready; @(posedge clk); n++; end while (!got && n < 200);
            #1 wvalid = 0;
            if (!got) begin check_val("w_timeout", 0, 1); return; end
            a = beat_addr(addr, size, len, burst, i);
            if (is_oob(a)) err = 1;
            else for (int b = 0; b < 4; b++)
                if (sq[i][b]) ref_mem[a[13:2]][8*b +: 8] = wq[i][8*b +: 8];
            if (wlast != (i == int'(len))) err = 1;
        end
        wlast = 0;
        bready = 1;
        @(negedge clk);
        check_val("b_latency", 32'(bvalid), 1);
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check_val("bid", 32'(bid), 32'(id));
        check_val("bresp", 32'(bresp), err ? 32'h2 : 32'h0);
        @(posedge clk); #1 bready = 0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stalls);
        bit got, first;
        int n;
        logic [29:0] a;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        n = 0;
        do begin @(negedge clk); got = arready; @(posedge clk); n++; end while (!got && n < 200);
        #1 arvalid = 0;
        if (!got) begin check_val("ar_timeout", 0, 1); return; end
        rready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
        first = 1;
        for (int i = 0; i <= int'(len); i++) begin
            got = 0; n = 0;
            while (!got && n < 100) begin
                @(negedge clk);
                if (first) begin check_val("r_latency", 32'(rvalid), 1); first = 0; end
                if (rvalid && rready) got = 1;
                else begin
                    @(posedge clk); #1;
                    rready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                    n++;
                end
            end
            if (!got) begin check_val("r_timeout", 0, 1); rready = 0; return; end
            a = beat_addr(addr, size, len, burst, i);
            check_val("rdata", rdata, is_oob(a) ? 32'h0 : ref_mem[a[13:2]]);
            check_val("rresp", 32'(rresp), is_oob(a) ? 32'h2 : 32'h0);
            check_val("rid", 32'(rid), 32'(id));
            check_val("rlast", 32'(rlast), 32'(i == int'(len)));
            @(posedge clk); #1;
            rready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rready = 0;
        @(negedge clk);
        check_val("ar_reissue", 32'(arready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [29:0] addr;
        bit got;
        int n;

        rst = 1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_arready", 32'(arready), 0);
        check_val("rst_awready", 32'(awready), 0);
        check_val("rst_wready", 32'(wready), 0);
        check_val("rst_rvalid", 32'(rvalid), 0);
        check_val("rst_bvalid", 32'(bvalid), 0);
        check_val("rst_rlast", 32'(rlast), 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_rid_rresp", 32'({rid, rresp}), 0);
        check_val("rst_bid_bresp", 32'({bid, bresp}), 0);
        rst = 0;
        @(posedge clk); #1;
        check_val("post_rst_arready", 32'(arready), 1);
        check_val("post_rst_awready", 32'(awready), 1);

        // Known contents everywhere so any later read has a model value.
        for (int blk = 0; blk < 16; blk++) begin
            fill_data(256, 1);
            do_write(4'($urandom_range(0, 15)), 30'(blk * 1024), 8'd255, 3'd2, BURST_INCR, -1, 0);
        end

        // single beat write then read back
        wq = '{32'hDEADBEEF}; sq = '{4'hF};
        do_write(4'h1, 30'h10, 8'd0, 3'd2, BURST_INCR, -1, 0);
        do_read(4'hF, 30'h10, 8'd0, 3'd2, BURST_INCR, 0);
        // INCR and WRAP bursts
        do_read(4'h3, 30'h0, 8'd3, 3'd2, BURST_INCR, 0);
        do_read(4'h5, 30'h18, 8'd3, 3'd2, BURST_WRAP, 0);
        // partial strobe
        wq = '{32'h11223344}; sq = '{4'hF};
        do_write(4'h2, 30'h40, 8'd0, 3'd2, BURST_INCR, -1, 0);
        wq = '{32'hAABBCCDD}; sq = '{4'h5};
        do_write(4'h2, 30'h40, 8'd0, 3'd2, BURST_INCR, -1, 0);
        do_read(4'h6, 30'h40, 8'd0, 3'd2, BURST_INCR, 0);
        check_val("partial_strobe", rdata, 32'h11BB33DD);
        // out-of-range read and early wlast
        do_read(4'h7, 30'h4000, 8'd1, 3'd2, BURST_INCR, 0);
        fill_data(3, 1);
        do_write(4'h8, 30'h80, 8'd2, 3'd2, BURST_INCR, 1, 0);
        do_read(4'h9, 30'h80, 8'd2, 3'd2, BURST_INCR, 0);

        // overlapping read and write bursts on disjoint words
        fill_data(8, 0);
        fork
            do_read(4'h0, 30'h100, 8'd7, 3'd2, BURST_INCR, 1);
            do_write(4'hF, 30'h800, 8'd7, 3'd2, BURST_INCR, -1, 1);
        join
        do_read(4'hA, 30'h800, 8'd7, 3'd2, BURST_INCR, 0);

        // reset in the middle of a read burst
        @(posedge clk); #1;
        arid = 4'h4; araddr = 30'h200; arlen = 8'd7; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1;
        n = 0;
        do begin @(negedge clk); got = arready; @(posedge clk); n++; end while (!got && n < 50);
        #1 arvalid = 0; rready = 1;
        check_val("rst_test_ar", 32'(got), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        check_val("mid_rst_rvalid", 32'(rvalid), 0);
        check_val("mid_rst_arready", 32'(arready), 0);
        @(negedge clk); rst = 0; rready = 0;
        @(posedge clk); #1;
        check_val("rel_arready", 32'(arready), 1);
        check_val("rel_rvalid", 32'(rvalid), 0);
        // contents survive reset
        do_read(4'hB, 30'h200, 8'd3, 3'd2, BURST_INCR, 0);

        // randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            burst = 2'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 2));
            if (burst == BURST_WRAP) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else                     len = 8'($urandom_range(0, 15));
            addr = 30'($urandom_range(0, 16383));
            if ($urandom_range(0, 7) == 0) addr[14 + $urandom_range(0, 15)] = 1'b1;
            if (burst == BURST_WRAP) addr = addr & ~((30'd1 << size) - 30'd1);
            if ($urandom_range(0, 1) == 0) begin
                fill_data(int'(len) + 1, 0);
                do_write(4'($urandom), addr, len, size, burst,
                         ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1, 1);
            end else begin
                do_read(4'($urandom), addr, len, size, burst, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
